// File: rtl/mips_data_mem_responder_pkg.sv
// Shared types and constants for the MIPS memory responders.
// Error codes, lane geometry and default memory map.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_RANGE    = 2'b01,
    ERR_ALIGN    = 2'b10,
    ERR_CONFLICT = 2'b11
  } err_code_e;

  localparam int          LANE_W          = 8;
  localparam int          WORD_BYTES      = 4;
  localparam logic [31:0] DEF_BASE_ADDR   = 32'h0000_1000;
  localparam int          DEF_DEPTH_WORDS = 1024;

endpackage

// File: rtl/mips_data_mem_responder_if.sv
// Core-to-memory data bus: the core is master, the responder is slave.
interface mips_data_mem_responder_if;

  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [3:0]  byte_enable;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;

  modport master (
    output data_address, data_read, data_write, byte_enable, data_writedata,
    input  data_readdata
  );

  modport slave (
    input  data_address, data_read, data_write, byte_enable, data_writedata,
    output data_readdata
  );

endinterface

// File: rtl/mips_data_mem_responder_mem_access_check.sv
// Combinational access decode: word index, legality and prioritised error code.
// Shared by the data- and instruction-side responders.
module mem_access_check
  import mips_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int          DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int          IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic [31:0]      i_address,
  input  logic             i_read,
  input  logic             i_write,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_legal_rd,
  output logic             o_legal_wr,
  output logic             o_err,
  output err_code_e        o_err_code
);

  logic [31:0] w_offset;
  logic [31:0] w_word;
  logic        w_in_range;
  logic        w_aligned;
  logic        w_conflict;
  logic        w_req;

  assign w_offset   = i_address - BASE_ADDR;
  assign w_word     = w_offset >> 2;
  // Base check first so addresses below BASE never wrap into range.
  assign w_in_range = (i_address >= BASE_ADDR) && (w_word < 32'(DEPTH_WORDS));
  assign w_aligned  = (i_address[1:0] == 2'b00);
  assign w_conflict = i_read && i_write;
  assign w_req      = i_read || i_write;
  assign o_idx      = w_word[IDX_W-1:0];

  always_comb begin
    o_err_code = ERR_NONE;
    if (w_conflict)       o_err_code = ERR_CONFLICT;
    else if (!w_in_range) o_err_code = ERR_RANGE;
    else if (!w_aligned)  o_err_code = ERR_ALIGN;
  end

  assign o_err      = w_req && (o_err_code != ERR_NONE);
  assign o_legal_rd = i_read  && (o_err_code == ERR_NONE);
  assign o_legal_wr = i_write && (o_err_code == ERR_NONE);

endmodule

// File: rtl/mips_data_mem_responder.sv
// Data-memory target for the Harvard MIPS core: byte-lane word RAM, combinational
// read, clocked write, sticky first-error capture and saturating access counters.
module mips_data_mem_responder
  import mips_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int          DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int          CNT_W       = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clk_enable,
  mips_data_mem_responder_if.slave   bus,
  output logic                       err_valid,
  output logic [1:0]                 err_code,
  output logic [31:0]                err_address,
  output logic [CNT_W-1:0]           rd_count,
  output logic [CNT_W-1:0]           wr_count
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0]      r_mem [DEPTH_WORDS];
  logic             r_err_valid;
  err_code_e        r_err_code;
  logic [31:0]      r_err_address;
  logic [CNT_W-1:0] r_rd_count;
  logic [CNT_W-1:0] r_wr_count;

  logic [IDX_W-1:0] w_idx;
  logic             w_legal_rd;
  logic             w_legal_wr;
  logic             w_err;
  err_code_e        w_err_code;

  mem_access_check #(
    .BASE_ADDR   (BASE_ADDR),
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_check (
    .i_address  (bus.data_address),
    .i_read     (bus.data_read),
    .i_write    (bus.data_write),
    .o_idx      (w_idx),
    .o_legal_rd (w_legal_rd),
    .o_legal_wr (w_legal_wr),
    .o_err      (w_err),
    .o_err_code (w_err_code)
  );

  assign bus.data_readdata = w_legal_rd ? r_mem[w_idx] : 32'h0;

  // Storage is not reset; the reset term only drops a write seen while in reset.
  always_ff @(posedge clk) begin
    if (reset && clk_enable && w_legal_wr) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (bus.byte_enable[i]) begin
          r_mem[w_idx][i*LANE_W +: LANE_W] <= bus.data_writedata[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_valid   <= 1'b0;
      r_err_code    <= ERR_NONE;
      r_err_address <= 32'h0;
      r_rd_count    <= '0;
      r_wr_count    <= '0;
    end else if (clk_enable) begin
      if (w_err && !r_err_valid) begin
        r_err_valid   <= 1'b1;
        r_err_code    <= w_err_code;
        r_err_address <= bus.data_address;
      end
      if (w_legal_rd && (r_rd_count != {CNT_W{1'b1}})) r_rd_count <= r_rd_count + 1'b1;
      if (w_legal_wr && (r_wr_count != {CNT_W{1'b1}})) r_wr_count <= r_wr_count + 1'b1;
    end
  end

  assign err_valid   = r_err_valid;
  assign err_code    = r_err_code;
  assign err_address = r_err_address;
  assign rd_count    = r_rd_count;
  assign wr_count    = r_wr_count;

endmodule

// File: tb/tb_mips_data_mem_responder.sv
// Directed bench for mips_data_mem_responder: inputs change on the falling edge,
// checks are taken 1ns later, well away from the rising edge.
module tb_mips_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [31:0] err_address;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  int n_chk  = 0;
  int n_pass = 0;

  mips_data_mem_responder_if bus ();

  mips_data_mem_responder #(
    .BASE_ADDR   (32'h0000_1000),
    .DEPTH_WORDS (1024),
    .CNT_W       (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clk_enable  (clk_enable),
    .bus         (bus),
    .err_valid   (err_valid),
    .err_code    (err_code),
    .err_address (err_address),
    .rd_count    (rd_count),
    .wr_count    (wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic acc(input logic [31:0] a, input logic rd, input logic wr,
                     input logic [3:0] be, input logic [31:0] wd);
    @(negedge clk);
    bus.data_address   = a;
    bus.data_read      = rd;
    bus.data_write     = wr;
    bus.byte_enable    = be;
    bus.data_writedata = wd;
    #1;
  endtask

  task automatic idle();
    acc(32'h0, 1'b0, 1'b0, 4'h0, 32'h0);
  endtask

  initial begin
    reset              = 1'b0;
    clk_enable         = 1'b1;
    bus.data_address   = 32'h0;
    bus.data_read      = 1'b0;
    bus.data_write     = 1'b0;
    bus.byte_enable    = 4'h0;
    bus.data_writedata = 32'h0;

    repeat (3) idle();
    chk("rst_err_valid", 32'(err_valid), 32'h0);
    chk("rst_err_code",  32'(err_code),  32'h0);
    chk("rst_rd_count",  32'(rd_count),  32'h0);
    chk("rst_wr_count",  32'(wr_count),  32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Full-word write then read back
    acc(32'h1000, 1'b0, 1'b1, 4'b1111, 32'hDEADBEEF);
    acc(32'h1000, 1'b1, 1'b0, 4'b0000, 32'h0);
    chk("full_rd", bus.data_readdata, 32'hDEADBEEF);
    idle();
    chk("full_wr_count", 32'(wr_count), 32'd1);
    chk("full_rd_count", 32'(rd_count), 32'd1);

    // Partial-lane write merges with existing word
    acc(32'h1004, 1'b0, 1'b1, 4'b1111, 32'h11223344);
    acc(32'h1004, 1'b0, 1'b1, 4'b0101, 32'hAABBCCDD);
    acc(32'h1004, 1'b1, 1'b0, 4'b1111, 32'h0);
    chk("lane_rd", bus.data_readdata, 32'h11BB33DD);

    // Out-of-range below base, then a misaligned access must not overwrite it
    acc(32'h0FFC, 1'b1, 1'b0, 4'b1111, 32'h0);
    chk("oor_rd_zero", bus.data_readdata, 32'h0);
    idle();
    chk("oor_err_valid", 32'(err_valid), 32'h1);
    chk("oor_err_code",  32'(err_code),  32'h1);
    chk("oor_err_addr",  err_address,    32'h0FFC);
    chk("oor_rd_count",  32'(rd_count),  32'd2);
    acc(32'h1001, 1'b1, 1'b0, 4'b1111, 32'h0);
    chk("mis_rd_zero", bus.data_readdata, 32'h0);
    idle();
    chk("first_err_kept", 32'(err_code), 32'h1);

    // Reset pulse clears error/counters; memory survives
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Misaligned + conflict: conflict wins, nothing changes
    acc(32'h1002, 1'b1, 1'b1, 4'b1111, 32'hFFFFFFFF);
    chk("cf_rd_zero", bus.data_readdata, 32'h0);
    idle();
    chk("cf_err_code",  32'(err_code),  32'h3);
    chk("cf_err_addr",  err_address,    32'h1002);
    chk("cf_wr_count",  32'(wr_count),  32'd0);
    chk("cf_rd_count",  32'(rd_count),  32'd0);
    acc(32'h1000, 1'b1, 1'b0, 4'b1111, 32'h0);
    chk("cf_mem_kept", bus.data_readdata, 32'hDEADBEEF);

    // clk_enable low: write dropped, reads still answer, no counting
    clk_enable = 1'b0;
    acc(32'h1000, 1'b0, 1'b1, 4'b1111, 32'h0);
    acc(32'h1004, 1'b1, 1'b0, 4'b1111, 32'h0);
    chk("hold_rd", bus.data_readdata, 32'h11BB33DD);
    @(negedge clk);
    clk_enable = 1'b1;
    acc(32'h1000, 1'b1, 1'b0, 4'b1111, 32'h0);
    chk("hold_no_write", bus.data_readdata, 32'hDEADBEEF);

    // Last word accepted, one past it rejected
    acc(32'h1FFC, 1'b0, 1'b1, 4'b1111, 32'h12345678);
    acc(32'h1FFC, 1'b1, 1'b0, 4'b1111, 32'h0);
    chk("last_word_rd", bus.data_readdata, 32'h12345678);
    acc(32'h2000, 1'b1, 1'b0, 4'b1111, 32'h0);
    chk("past_end_zero", bus.data_readdata, 32'h0);
    idle();
    chk("bnd_rd_count", 32'(rd_count), 32'd3);
    chk("bnd_wr_count", 32'(wr_count), 32'd1);
    chk("bnd_err_code", 32'(err_code), 32'h3);

    // Bring wr_count to 5, then reset asynchronously mid-cycle
    acc(32'h1008, 1'b0, 1'b1, 4'b1111, 32'h01010101);
    acc(32'h100C, 1'b0, 1'b1, 4'b1111, 32'h02020202);
    acc(32'h1010, 1'b0, 1'b1, 4'b0000, 32'h03030303);
    acc(32'h1008, 1'b0, 1'b1, 4'b1111, 32'hCAFEF00D);
    idle();
    chk("pre_rst_wr_count", 32'(wr_count), 32'd5);
    #1;
    reset = 1'b0;
    #1;
    chk("arst_wr_count",  32'(wr_count),  32'd0);
    chk("arst_err_valid", 32'(err_valid), 32'h0);
    chk("arst_err_addr",  err_address,    32'h0);
    acc(32'h1000, 1'b1, 1'b0, 4'b1111, 32'h0);
    chk("rst_comb_rd", bus.data_readdata, 32'hDEADBEEF);
    @(negedge clk);
    reset = 1'b1;
    acc(32'h1008, 1'b1, 1'b0, 4'b1111, 32'h0);
    chk("post_rst_rd", bus.data_readdata, 32'hCAFEF00D);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mips_data_mem_responder.md
Name: mips_data_mem_responder

Overview:
- Data-memory responder for the Harvard MIPS core: the target end of the core's data_address/data_read/data_write/byte_enable/data_writedata/data_readdata interface.
- Holds a byte-lane-writable word RAM mapped at a fixed base address, with combinational read and clocked write.
- Keeps sticky first-error capture and saturating access counters for testbench and debug observation.
- Sits beside the CPU in the harvard testbench/top, one instance per data space.

Parameters:
- BASE_ADDR, 32'h0000_1000, byte address of word 0; must be word-aligned.
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, at least 4.
- CNT_W, 16, width of the read/write access counters.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset; 0 = in reset.
- clk_enable  input  1  qualifies every state update; when 0, memory, counters and flags hold.
- data_address  input  32  byte address from the core.
- data_read  input  1  read request, same-cycle response.
- data_write  input  1  write request, committed at the next rising clk.
- byte_enable  input  4  lane mask; bit i selects bits [8i+7:8i].
- data_writedata  input  32  write data; lanes are already aligned by the core.
- data_readdata  output  32  read data, combinational.
- err_valid  output  1  sticky; an illegal access has been seen.
- err_code  output  2  code of the first error: 01 out-of-range, 10 misaligned, 11 read+write conflict.
- err_address  output  32  data_address of the first error.
- rd_count  output  CNT_W  accepted reads, saturating.
- wr_count  output  CNT_W  accepted writes, saturating.

Behaviour:
- Decode:
  - idx = (data_address - BASE_ADDR) >> 2.
  - in_range = (data_address >= BASE_ADDR) and (idx < DEPTH_WORDS), computed on the 32-bit unsigned value; no wrap-around.
  - aligned = (data_address[1:0] == 0).
  - conflict = data_read and data_write.
- Legal access: request asserted, in_range, aligned, no conflict.
- Read path (combinational):
  - Legal read: data_readdata = mem[idx], full word regardless of byte_enable. The core does its own lane selection and sign-extension.
  - Any other case: data_readdata = 32'h0.
  - Read-during-write to the same word returns the pre-write contents; the write lands at the clock edge.
- Write path: at posedge clk, if reset=1, clk_enable=1 and the write is legal, each lane i with byte_enable[i]=1 takes the matching lane of data_writedata. Lanes with a 0 enable are unchanged. byte_enable=0000 is legal and is counted, but modifies nothing.
- Illegal accesses:
  - No memory modification.
  - Read returns 0.
  - Counters do not increment.
- Error capture, evaluated at posedge when clk_enable=1 and data_read or data_write is asserted:
  - Priority when several errors hold at once: conflict (11) > out-of-range (01) > misaligned (10).
  - If err_valid=0, load err_code and err_address and set err_valid.
  - If err_valid=1, hold; only the first error is kept.
- Counters:
  - rd_count increments on each enabled clock edge with a legal read.
  - wr_count increments on each enabled clock edge with a legal write.
  - Both saturate at all-ones and never wrap.
- Reset:
  - Asynchronous assertion clears err_valid, err_code, err_address, rd_count and wr_count to 0 immediately, including mid-access.
  - Memory contents are not reset.
  - data_readdata remains combinational during reset.
  - A write pending on an edge while reset=0 is dropped.
  - Deassertion is synchronised by the integrator; no state changes on the deassertion edge itself.
- clk_enable=0: requests are still decoded and reads still return data, but no write, count or error update occurs.
- Latency: read 0 cycles; write visible to a read one cycle after the committing edge.

Decomposition:
- Package mips_mem_pkg:
  - err_code enum: ERR_NONE=00, ERR_RANGE=01, ERR_ALIGN=10, ERR_CONFLICT=11.
  - Lane-width constant (8) and word-byte constant (4).
  - Default BASE_ADDR and DEPTH_WORDS constants, shared with the instruction-memory model.
- Sub-module mem_access_check: combinational in_range/aligned/conflict/idx decode plus the prioritised err_code. It is reusable by the instruction-side responder.
- Storage, counters and error registers live in the top.

Test Plan:
- Full write: reset, then write 32'hDEADBEEF to 0x1000 with be=1111; next cycle read 0x1000 -> data_readdata=32'hDEADBEEF, wr_count=1, rd_count=1.
- Byte lanes: preload 0x1004=32'h11223344; write 32'hAABBCCDD with be=0101 -> read returns 32'h11BB33DD.
- Out-of-range: read 0x0FFC -> data_readdata=0, err_valid=1, err_code=01, err_address=0x0FFC. A following misaligned access leaves err_code=01.
- Conflict priority: read+write together to 0x1002 (misaligned and conflicting) -> err_code=11, memory unchanged, counters unchanged.
- Hold and boundary: clk_enable=0 write to 0x1000 -> no change. Then, with clk_enable=1, write to the last word BASE_ADDR+4*(DEPTH_WORDS-1) -> accepted, no error.
- Async reset: assert reset mid-cycle while wr_count=5 and err_valid=1 -> both clear immediately without a clock edge; the earlier write data is still readable after release.
